// File: rtl/otp_entry.sv
// Push-button OTP entry: per-button sync/debounce/edge detect feeding a cursor-based
// BCD digit editor that hands the finished code over with a valid/ack handshake.
module otp_entry #(
  parameter int unsigned DB_CYCLES = 250000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_inc,
  input  logic        btn_next,
  input  logic        btn_clr,
  input  logic        btn_submit,
  input  logic        entry_en,
  input  logic        otp_ack,
  output logic [15:0] user_otp,
  output logic [1:0]  cursor,
  output logic        entering,
  output logic        otp_valid
);

  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ENTRY, SUBMIT} state_t;

  state_t        state;
  logic [3:0]    raw;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    level;
  logic [3:0]    level_q;
  logic [3:0]    ev;
  logic [CW-1:0] cnt [4];
  logic [3:0]    cur_dig;
  logic          ev_inc, ev_next, ev_clr, ev_submit;

  assign raw = {btn_submit, btn_clr, btn_next, btn_inc};

  // Bit order of raw/ev: 0=inc, 1=next, 2=clr, 3=submit
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_q <= '0;
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          level[i] <= ~level[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  assign ev        = level & ~level_q;
  assign ev_inc    = ev[0];
  assign ev_next   = ev[1];
  assign ev_clr    = ev[2];
  assign ev_submit = ev[3];

  assign cur_dig = user_otp[{cursor, 2'b00} +: 4];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      user_otp  <= '0;
      cursor    <= 2'd3;
      entering  <= 1'b0;
      otp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (entry_en) begin
            state    <= ENTRY;
            user_otp <= '0;
            cursor   <= 2'd3;
            entering <= 1'b1;
          end
        end
        ENTRY: begin
          if (!entry_en) begin
            state    <= IDLE;
            user_otp <= '0;
            cursor   <= 2'd3;
            entering <= 1'b0;
          end else if (ev_clr) begin
            user_otp <= '0;
            cursor   <= 2'd3;
          end else if (ev_submit) begin
            state     <= SUBMIT;
            entering  <= 1'b0;
            otp_valid <= 1'b1;
          end else if (ev_next) begin
            cursor <= cursor - 2'd1;
          end else if (ev_inc) begin
            user_otp[{cursor, 2'b00} +: 4] <= (cur_dig == 4'd9) ? 4'd0 : cur_dig + 4'd1;
          end
        end
        SUBMIT: begin
          if (!entry_en) begin
            state     <= IDLE;
            otp_valid <= 1'b0;
            user_otp  <= '0;
            cursor    <= 2'd3;
          end else if (otp_ack) begin
            state     <= ENTRY;
            otp_valid <= 1'b0;
            entering  <= 1'b1;
            user_otp  <= '0;
            cursor    <= 2'd3;
          end
        end
        default: begin
          state     <= IDLE;
          entering  <= 1'b0;
          otp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
